// File: rtl/adder_8_resp_checker_pkg.sv
// Shared types for the adder_8 response checker: verdict states and vector/result layouts.
package adder_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;

  localparam int W_DEF = 8;

  typedef struct packed {
    logic [W_DEF-1:0] a;
    logic [W_DEF-1:0] b;
    logic             ci;
  } vec_t;

  typedef struct packed {
    logic             co;
    logic             os;
    logic [W_DEF-1:0] s;
  } res_t;

endpackage

// File: rtl/adder_8_resp_checker_ref.sv
// Combinational golden model of the W-bit adder: sum, carry-out and signed overflow.
module adder_8_ref #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         os
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

  // Overflow only when both operands share a sign and the result flips it.
  assign os = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);

endmodule

// File: rtl/adder_8_resp_checker.sv
// Scoreboard for adder_8: samples on smp_valid, compares in stage 2, counts/verdict in stage 3
// (2 clk sample-to-count). No backpressure; one sample per cycle, extras beyond a run are dropped.
module adder_8_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int N_VECTORS = 6,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             ci,
  input  logic [W-1:0]     s,
  input  logic             co,
  input  logic             os,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*W:0]     fail_vec,
  output logic [W+1:0]     fail_got
);

  localparam int SW = $clog2(N_VECTORS + 2);
  localparam logic [SW-1:0] N_LAST = SW'(N_VECTORS);

  chk_state_t state;

  logic           v1;
  logic [W-1:0]   a1, b1, s1;
  logic           ci1, co1, os1;

  logic           v2;
  logic           mis2;
  logic [2*W:0]   vec2;
  logic [W+1:0]   got2;

  logic [SW-1:0]  smp_cnt;
  logic [SW-1:0]  ret_cnt;

  logic [W-1:0]   ref_s;
  logic           ref_co, ref_os;
  logic           accept;
  logic           retire_last;

  adder_8_ref #(.W(W)) u_ref (
    .a  (a1),
    .b  (b1),
    .ci (ci1),
    .s  (ref_s),
    .co (ref_co),
    .os (ref_os)
  );

  assign accept      = smp_valid && (state == RUN) && (smp_cnt < N_LAST);
  assign retire_last = v2 && ((ret_cnt + SW'(1)) == N_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      s1        <= '0;
      ci1       <= 1'b0;
      co1       <= 1'b0;
      os1       <= 1'b0;
      v2        <= 1'b0;
      mis2      <= 1'b0;
      vec2      <= '0;
      got2      <= '0;
      smp_cnt   <= '0;
      ret_cnt   <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_got  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (start) begin
      // Restart from any state; anything in flight belongs to the old run.
      state     <= RUN;
      v1        <= 1'b0;
      v2        <= 1'b0;
      mis2      <= 1'b0;
      smp_cnt   <= '0;
      ret_cnt   <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_got  <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1      <= a;
        b1      <= b;
        ci1     <= ci;
        s1      <= s;
        co1     <= co;
        os1     <= os;
        smp_cnt <= smp_cnt + SW'(1);
      end

      v2 <= v1;
      if (v1) begin
        mis2 <= {co1, os1, s1} != {ref_co, ref_os, ref_s};
        vec2 <= {a1, b1, ci1};
        got2 <= {co1, os1, s1};
      end

      if (v2) begin
        ret_cnt <= ret_cnt + SW'(1);
        if (mis2) begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          if (err_cnt == '0) begin
            fail_vec <= vec2;
            fail_got <= got2;
          end
        end else if (match_cnt != '1) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end

      case (state)
        RUN: begin
          if (N_VECTORS == 0) begin
            state <= PASS;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (retire_last) begin
            // Verdict must include the sample retiring this very cycle.
            state <= (err_cnt == '0 && !mis2) ? PASS : FAIL;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == '0 && !mis2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_8_resp_checker.sv
module tb_adder_8_resp_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        smp_valid;
  logic [7:0]  a, b, s;
  logic        ci, co, os;

  logic [15:0] match_cnt, err_cnt;
  logic        busy, done, pass;
  logic [16:0] fail_vec;
  logic [9:0]  fail_got;

  logic [1:0]  sat_match, sat_err;
  logic        sat_busy, sat_done, sat_pass;
  logic [16:0] sat_vec;
  logic [9:0]  sat_got;

  logic [15:0] zero_match, zero_err;
  logic        zero_busy, zero_done, zero_pass;
  logic [16:0] zero_vec;
  logic [9:0]  zero_got;

  always #5 clk = ~clk;

  adder_8_resp_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .ci(ci), .s(s), .co(co), .os(os),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .busy(busy), .done(done), .pass(pass),
    .fail_vec(fail_vec), .fail_got(fail_got)
  );

  adder_8_resp_checker #(.W(8), .N_VECTORS(6), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .ci(ci), .s(s), .co(co), .os(os),
    .match_cnt(sat_match), .err_cnt(sat_err), .busy(sat_busy), .done(sat_done), .pass(sat_pass),
    .fail_vec(sat_vec), .fail_got(sat_got)
  );

  adder_8_resp_checker #(.W(8), .N_VECTORS(0), .CNT_W(16)) u_zero (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .ci(ci), .s(s), .co(co), .os(os),
    .match_cnt(zero_match), .err_cnt(zero_err), .busy(zero_busy), .done(zero_done), .pass(zero_pass),
    .fail_vec(zero_vec), .fail_got(zero_got)
  );

  typedef struct {
    int due;
    int m;
    int e;
  } sb_t;

  sb_t         sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_m, exp_e;
  bit          have_fail;
  logic [16:0] exp_fv;
  logic [9:0]  exp_fg;
  int          last_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counter values expected once each accepted sample has retired.
  always @(negedge clk) begin
    sb_t ent;
    if (sb.size() != 0 && cyc >= sb[0].due) begin
      ent = sb.pop_front();
      check_val("sb_match_cnt", match_cnt, ent.m);
      check_val("sb_err_cnt", err_cnt, ent.e);
    end
  end

  task automatic clear_model();
    sb.delete();
    exp_m = 0;
    exp_e = 0;
    have_fail = 0;
    exp_fv = '0;
    exp_fg = '0;
  endtask

  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vci,
                       input logic [9:0] flip, input bit acc);
    int sum, ssum;
    logic [9:0] gold, got;
    @(posedge clk); #1;
    sum  = va + vb + vci;
    ssum = int'($signed(va)) + int'($signed(vb)) + int'(vci);
    gold = {(sum > 255) ? 1'b1 : 1'b0, (ssum > 127 || ssum < -128) ? 1'b1 : 1'b0, sum[7:0]};
    got  = gold ^ flip;
    a = va; b = vb; ci = vci;
    {co, os, s} = got;
    smp_valid = 1'b1;
    last_cyc = cyc;
    if (acc) begin
      if (flip != 10'h000) begin
        exp_e++;
        if (!have_fail) begin
          have_fail = 1;
          exp_fv = {va, vb, vci};
          exp_fg = got;
        end
      end else begin
        exp_m++;
      end
      sb.push_back('{cyc + 3, exp_m, exp_e});
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    start = 1'b1;
    smp_valid = 1'b0;
    clear_model();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check_val(tag, done, 1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_match"}, match_cnt, 0);
    check_val({tag, "_err"}, err_cnt, 0);
    check_val({tag, "_flags"}, {busy, done, pass}, 0);
    check_val({tag, "_vec"}, fail_vec, 0);
    check_val({tag, "_got"}, fail_got, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; smp_valid = 1'b0;
    a = '0; b = '0; ci = 1'b0; s = '0; co = 1'b0; os = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check_val("reset_zero_flags", {zero_busy, zero_done, zero_pass}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of a run, then unrequested samples.
    start_run();
    drive(8'h10, 8'h20, 1'b0, 10'h000, 1);
    drive(8'h7F, 8'h01, 1'b0, 10'h100, 1);
    @(posedge clk); #1;
    rst = 1'b1; smp_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrun_rst");
    drive(8'h01, 8'h01, 1'b0, 10'h000, 0);
    drive(8'h02, 8'h02, 1'b0, 10'h001, 0);
    idle();
    repeat (4) @(negedge clk);
    check_all_zero("idle_ignored");

    // Six correct vectors plus a seventh that must be ignored.
    start_run();
    @(negedge clk);
    check_val("zero_busy", zero_busy, 1);
    @(negedge clk);
    check_val("zero_pass", {zero_done, zero_pass}, 2'b11);
    drive(8'hF6, 8'h0A, 1'b0, 10'h000, 1);
    drive(8'h01, 8'h02, 1'b1, 10'h000, 1);
    drive(8'h80, 8'h80, 1'b0, 10'h000, 1);
    drive(8'hFF, 8'hFF, 1'b1, 10'h000, 1);
    drive(8'h55, 8'h2A, 1'b0, 10'h000, 1);
    drive(8'h7F, 8'h7F, 1'b1, 10'h000, 1);
    drive(8'h12, 8'h34, 1'b0, 10'h000, 0);
    idle();
    @(negedge clk);
    check_val("done_early", done, 0);
    @(negedge clk);
    check_val("done_on_time", done, 1);
    wait_done("pass_done");
    check_val("pass_flag", {busy, pass}, 2'b01);
    check_val("pass_match", match_cnt, 6);
    check_val("pass_err", err_cnt, 0);
    check_val("pass_vec", fail_vec, 0);

    // Injected overflow error on 7F+01+0.
    start_run();
    drive(8'h7F, 8'h01, 1'b0, 10'h100, 1);
    drive(8'h00, 8'h00, 1'b0, 10'h000, 1);
    drive(8'hF0, 8'h20, 1'b1, 10'h000, 1);
    drive(8'h80, 8'hFF, 1'b0, 10'h000, 1);
    drive(8'h3C, 8'h44, 1'b0, 10'h000, 1);
    drive(8'hAA, 8'h55, 1'b1, 10'h000, 1);
    idle();
    wait_done("ovf_done");
    check_val("ovf_pass", pass, 0);
    check_val("ovf_err", err_cnt, 1);
    check_val("ovf_vec", fail_vec, 17'h0FE02);
    check_val("ovf_got", fail_got, 10'h080);

    // Two mismatches: the first one stays captured.
    start_run();
    drive(8'h11, 8'h22, 1'b0, 10'h000, 1);
    drive(8'h33, 8'h44, 1'b1, 10'h000, 1);
    drive(8'hC8, 8'h64, 1'b0, 10'h001, 1);
    drive(8'h90, 8'h90, 1'b1, 10'h000, 1);
    drive(8'h01, 8'hFE, 1'b1, 10'h040, 1);
    drive(8'h0F, 8'hF1, 1'b0, 10'h000, 1);
    idle();
    wait_done("two_done");
    check_val("two_err", err_cnt, 2);
    check_val("two_match", match_cnt, 4);
    check_val("two_vec", fail_vec, exp_fv);
    check_val("two_got", fail_got, exp_fg);
    check_val("two_pass", pass, 0);

    // Restart coinciding with the fourth sample.
    start_run();
    drive(8'h01, 8'h01, 1'b0, 10'h000, 1);
    drive(8'h02, 8'h03, 1'b0, 10'h000, 1);
    drive(8'h04, 8'h05, 1'b0, 10'h001, 1);
    drive(8'h06, 8'h07, 1'b0, 10'h000, 0);
    start = 1'b1;
    clear_model();
    @(posedge clk); #1;
    start = 1'b0; smp_valid = 1'b0;
    @(negedge clk);
    check_val("restart_match", match_cnt, 0);
    check_val("restart_err", err_cnt, 0);
    check_val("restart_busy", {busy, done}, 2'b10);
    for (int i = 0; i < 5; i++) drive(8'(i * 37), 8'(200 - i), 1'(i), 10'h000, 1);
    idle();
    repeat (4) @(negedge clk);
    check_val("restart_not_done", done, 0);
    drive(8'hE0, 8'h20, 1'b0, 10'h000, 1);
    idle();
    wait_done("restart_done");
    check_val("restart_pass", pass, 1);
    check_val("restart_final", match_cnt, 6);

    // All bad: the narrow-counter instance saturates.
    start_run();
    for (int i = 0; i < 6; i++) drive(8'(i * 50), 8'(i * 13 + 1), 1'(i), 10'h200, 1);
    idle();
    wait_done("sat_done");
    check_val("sat_err", sat_err, 3);
    check_val("sat_match", sat_match, 0);
    check_val("sat_verdict", {sat_done, sat_pass}, 2'b10);
    check_val("wide_err", err_cnt, 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
